vscpu_hs: RTL and testbench
===========================

Name: vscpu_hs

Overview:
- Parametrised multi-cycle memory-to-memory CPU. Executes the 8-opcode VSCPU ISA, with register and immediate forms of each opcode.
- Generalised in data and address width over the base core.
- Adds a request/ready memory handshake with arbitrary wait states, a retired-instruction counter, and halt detection on self-branch.
- Sits between the top level and a single-port RAM or a bus adapter.

Parameters:
- DATA_W, 32, memory word and instruction width. Must satisfy DATA_W >= 2*ADDR_W+4.
- ADDR_W, 14, word-address width. PC is ADDR_W bits.
- CNT_W, 32, width of instr_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read. Valid while mem_req=1.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data. Valid in the cycle where mem_rdy=1.
- mem_rdy  in  1  access completes at the rising edge where mem_req=1 and mem_rdy=1.
- halted  out  1  core stopped on self-branch.
- instr_count  out  CNT_W  retired instructions. Wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FETCH, pc=0, iw/ra/rb=0, instr_count=0, halted=0.
  - mem_req, mem_we, mem_addr and mem_wdata are forced to 0 combinationally while rst=0, including mid-access.
- mem_* outputs are combinational from state and registers, gated by rst. The first fetch request appears in the cycle rst rises.
- Handshake:
  - While mem_req=1 and mem_rdy=0, mem_we/mem_addr/mem_wdata must stay stable and state holds.
  - mem_rdy is ignored when mem_req=0.
- Encoding:
  - opc = iw[DATA_W-1:DATA_W-3]
  - imm = iw[DATA_W-4]
  - A = iw[2*ADDR_W-1:ADDR_W]
  - B = iw[ADDR_W-1:0]
  - Bits in between are ignored.
  - Immediate B is zero-extended to DATA_W.
- States: FETCH, LD_A, LD_B, LD_IND, WRITE, HALT. Every state except HALT issues one access and advances only on ready.
- FETCH reads mem[pc] into iw. Per-opcode sequence:
  - ADD/NAND/SRL/LT/MUL, imm=0: LD_A (ra=*A) -> LD_B (rb=*B) -> WRITE *A=f(ra,rb).
  - Same opcodes, imm=1: LD_A -> WRITE *A=f(ra,B).
  - CP (100,0): LD_B -> WRITE *A=rb.
  - CPi (100,1): WRITE *A=B.
  - CPI (101,0): LD_B -> LD_IND (rb=mem[rb[ADDR_W-1:0]]) -> WRITE *A=rb.
  - CPIi (101,1): LD_A -> WRITE mem[ra[ADDR_W-1:0]]=B.
  - BZJ (110,0): LD_B. If rb!=0, pc=pc+1 and retire. Else LD_A, then pc=ra[ADDR_W-1:0].
  - BZJi (110,1): LD_A, then pc=(ra+B)[ADDR_W-1:0].
- Opcode 111 is MUL/MULi.
- Arithmetic:
  - Results are truncated to DATA_W. MUL keeps the low DATA_W bits.
  - NAND is bitwise.
  - LT is unsigned: 1 if ra<operand, else 0.
  - SRL, with operand s unsigned:
    - s<DATA_W: ra>>s.
    - DATA_W<=s<2*DATA_W: ra<<(s-DATA_W).
    - otherwise 0.
- Retire:
  - Non-branches retire at the WRITE-ack edge with pc=pc+1 (wraps at 2^ADDR_W).
  - Branches retire at their last read-ack edge.
  - instr_count increments by 1 at every retire. Next state is FETCH.
- Halt:
  - If a branch retires with new pc equal to the current pc, it still counts as retired, halted=1 and state=HALT.
  - In HALT there are no requests and no state change until reset.
- Latency with zero wait states:
  - reg ALU: 4 cycles
  - imm ALU, CP, CPIi: 3
  - CPi: 2
  - CPI: 4
  - BZJ not-taken: 2, taken: 3
  - BZJi: 2
  - Each wait cycle adds 1.

Test Plan:
- ADD, DATA_W=32/ADDR_W=14, mem_rdy tied 1: mem[0]=0x00190065, mem[100]=5, mem[101]=7 -> write mem[100]=12 on cycle 4; pc=1; instr_count=1.
- Same program with mem_rdy asserted only every 4th cycle -> addr/we/wdata stable during waits; ADD retires at cycle 16 with the same result.
- SRL reg: *A=0x80, *B=4 -> 0x8. With *B=33 -> 0x100. With *B=64 -> 0. SRLi B=3 on 0x80 -> 0x10.
- CPI: *B=200, mem[200]=0xDEAD -> *A=0xDEAD. CPIi: *A=300, B=9 -> mem[300]=9, mem[A] unchanged.
- BZJ:
  - *B=1 -> pc+1.
  - *B=0, *A=40 -> pc=40.
  - BZJi at pc=5 with *A=0, B=5 -> halted=1, mem_req stays 0 for 20 cycles, instr_count counts the halting branch.
- rst driven low mid-WRITE with mem_rdy=0 -> mem_req/mem_we drop the same cycle. After rst rises: pc=0, instr_count=0, first fetch of mem[0].

Source files
------------

// File: rtl/vscpu_hs.sv
// vscpu_hs: multi-cycle, memory-to-memory VSCPU core with a req/rdy memory port.
//
// The core runs the 8-opcode VSCPU ISA in register (imm=0) and immediate
// (imm=1) forms. It counts retired instructions and stops for good when a
// branch targets its own address.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   mem_req      memory access request
//   mem_we       1 = write, 0 = read (meaningful while mem_req=1)
//   mem_addr     word address of the access
//   mem_wdata    write data
//   mem_rdata    read data, sampled on the completing edge
//   mem_rdy      the access completes on the rising edge where mem_req=1 and mem_rdy=1
//   halted       core stopped on a self-branch
//   instr_count  retired-instruction counter, wraps modulo 2^CNT_W
//
// Handshake: an access is presented when mem_req=1. The core keeps mem_we,
// mem_addr and mem_wdata unchanged until the edge where mem_req=1 and
// mem_rdy=1. Only at that edge does the core capture read data or advance
// its state. mem_rdy has no effect while mem_req=0.
//
// Instruction word layout:
//   [DATA_W-1:DATA_W-3]  opcode
//   [DATA_W-4]           immediate flag
//   [2*ADDR_W-1:ADDR_W]  field A
//   [ADDR_W-1:0]         field B
// Bits between the immediate flag and field A are ignored, so the
// instruction register keeps only the decoded fields.
//
// Requires DATA_W >= 2*ADDR_W+4.
module vscpu_hs #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        LD_A   = 3'd1,
        LD_B   = 3'd2,
        LD_IND = 3'd3,
        WRITE  = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_LT   = 3'b011;
    localparam logic [2:0] OP_CP   = 3'b100;
    localparam logic [2:0] OP_CPI  = 3'b101;
    localparam logic [2:0] OP_BZJ  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    // SRL thresholds. The shift operand is compared with one extra bit so
    // that 2*DATA_W fits.
    localparam logic [DATA_W:0]   SH_LIM1 = (DATA_W+1)'(DATA_W);
    localparam logic [DATA_W:0]   SH_LIM2 = (DATA_W+1)'(2*DATA_W);
    localparam logic [DATA_W-1:0] SH_DW   = DATA_W'(DATA_W);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [2:0]        opc, opc_nxt;
    logic              imm, imm_nxt;
    logic [ADDR_W-1:0] fa, fa_nxt;
    logic [ADDR_W-1:0] fb, fb_nxt;
    logic [DATA_W-1:0] ra, ra_nxt;
    logic [DATA_W-1:0] rb, rb_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              halted_nxt;

    logic [DATA_W-1:0] b_ext;
    logic [DATA_W-1:0] operand;
    logic [DATA_W:0]   sh_ext;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] pc_inc;
    logic              ack;
    logic              br_retire;
    logic [ADDR_W-1:0] br_target;

    assign b_ext   = {{(DATA_W-ADDR_W){1'b0}}, fb};
    assign operand = imm ? b_ext : rb;
    assign sh_ext  = {1'b0, operand};
    assign pc_inc  = pc + ADDR_W'(1);
    assign ack     = mem_req & mem_rdy;

    // ALU: the result is always truncated to DATA_W.
    always_comb begin
        alu_res = '0;
        case (opc)
            OP_ADD:  alu_res = ra + operand;
            OP_NAND: alu_res = ~(ra & operand);
            OP_SRL: begin
                // Shift amounts in [DATA_W, 2*DATA_W) become left shifts.
                // Larger amounts give 0.
                if (sh_ext < SH_LIM1) begin
                    alu_res = ra >> operand;
                end else if (sh_ext < SH_LIM2) begin
                    alu_res = ra << (operand - SH_DW);
                end else begin
                    alu_res = '0;
                end
            end
            OP_LT:   alu_res = {{(DATA_W-1){1'b0}}, (ra < operand)};
            OP_MUL:  alu_res = ra * operand;
            default: alu_res = '0;
        endcase
    end

    // Write-back address and data. These are built only from registers, so
    // they hold steady through wait states.
    always_comb begin
        wr_addr = fa;
        wr_data = alu_res;
        case (opc)
            OP_CP: wr_data = imm ? b_ext : rb;
            OP_CPI: begin
                wr_data = imm ? b_ext : rb;
                if (imm) begin
                    wr_addr = ra[ADDR_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // Memory port. Every output is held at 0 while reset is asserted.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst) begin
            case (state)
                FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc;
                end
                LD_A: begin
                    mem_req  = 1'b1;
                    mem_addr = fa;
                end
                LD_B: begin
                    mem_req  = 1'b1;
                    mem_addr = fb;
                end
                LD_IND: begin
                    mem_req  = 1'b1;
                    mem_addr = rb[ADDR_W-1:0];
                end
                WRITE: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic. Nothing changes unless the current access is acknowledged.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        opc_nxt    = opc;
        imm_nxt    = imm;
        fa_nxt     = fa;
        fb_nxt     = fb;
        ra_nxt     = ra;
        rb_nxt     = rb;
        cnt_nxt    = instr_count;
        halted_nxt = halted;
        br_retire  = 1'b0;
        br_target  = pc_inc;

        if (ack) begin
            case (state)
                FETCH: begin
                    opc_nxt = mem_rdata[DATA_W-1:DATA_W-3];
                    imm_nxt = mem_rdata[DATA_W-4];
                    fa_nxt  = mem_rdata[2*ADDR_W-1:ADDR_W];
                    fb_nxt  = mem_rdata[ADDR_W-1:0];
                    case (mem_rdata[DATA_W-1:DATA_W-3])
                        OP_CP:          state_nxt = mem_rdata[DATA_W-4] ? WRITE : LD_B;
                        OP_CPI, OP_BZJ: state_nxt = mem_rdata[DATA_W-4] ? LD_A : LD_B;
                        default:        state_nxt = LD_A;
                    endcase
                end
                LD_A: begin
                    ra_nxt = mem_rdata;
                    case (opc)
                        OP_CPI: state_nxt = WRITE;
                        OP_BZJ: begin
                            // Reg form reaches here only after a zero test value.
                            br_retire = 1'b1;
                            br_target = imm ? (mem_rdata[ADDR_W-1:0] + fb)
                                            : mem_rdata[ADDR_W-1:0];
                        end
                        default: state_nxt = imm ? WRITE : LD_B;
                    endcase
                end
                LD_B: begin
                    rb_nxt = mem_rdata;
                    case (opc)
                        OP_CPI: state_nxt = LD_IND;
                        OP_BZJ: begin
                            if (mem_rdata != '0) begin
                                br_retire = 1'b1;
                                br_target = pc_inc;
                            end else begin
                                state_nxt = LD_A;
                            end
                        end
                        default: state_nxt = WRITE;
                    endcase
                end
                LD_IND: begin
                    rb_nxt    = mem_rdata;
                    state_nxt = WRITE;
                end
                WRITE: begin
                    pc_nxt    = pc_inc;
                    cnt_nxt   = instr_count + CNT_W'(1);
                    state_nxt = FETCH;
                end
                default: ;
            endcase
        end

        // A retiring branch whose target is its own address stops the core.
        if (br_retire) begin
            pc_nxt  = br_target;
            cnt_nxt = instr_count + CNT_W'(1);
            if (br_target == pc) begin
                state_nxt  = HALT;
                halted_nxt = 1'b1;
            end else begin
                state_nxt = FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= '0;
            opc         <= '0;
            imm         <= 1'b0;
            fa          <= '0;
            fb          <= '0;
            ra          <= '0;
            rb          <= '0;
            instr_count <= '0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            opc         <= opc_nxt;
            imm         <= imm_nxt;
            fa          <= fa_nxt;
            fb          <= fb_nxt;
            ra          <= ra_nxt;
            rb          <= rb_nxt;
            instr_count <= cnt_nxt;
            halted      <= halted_nxt;
        end
    end

endmodule

// File: tb/tb_vscpu_hs.sv
`timescale 1ns/1ps
module tb_vscpu_hs;

    localparam int DW    = 32;
    localparam int AW    = 14;
    localparam int CW    = 32;
    localparam int MEM_N = 1 << AW;
    localparam int EW    = 2 + AW + DW + CW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_rdy;
    logic          halted;
    logic [CW-1:0] instr_count;

    // dmem is the memory the DUT sees. mm is the reference model's private copy.
    logic [DW-1:0] dmem [MEM_N];
    logic [DW-1:0] mm   [MEM_N];
    // Expected accesses, one entry each: {halted, we, addr, wdata (0 on reads), instr_count}.
    logic [EW-1:0] exp_q [$];

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            rdy_mode = 0;
    int            first_wr_cyc = 0;
    logic          m_halted;
    logic [CW-1:0] m_cnt;

    vscpu_hs #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_rdy     (mem_rdy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    assign mem_rdata = dmem[mem_addr];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] enc(input logic [2:0] op, input logic im,
                                          input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [DW-1:0] w;
        w = '0;
        w[DW-1:DW-3]   = op;
        w[DW-4]        = im;
        w[2*AW-1:AW]   = a;
        w[AW-1:0]      = b;
        return w;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < MEM_N; i++) dmem[i] = '0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] x,
                                              input logic [DW-1:0] y);
        longint unsigned s;
        s = 64'(y);
        case (op)
            3'd0: return x + y;
            3'd1: return ~(x & y);
            3'd2: begin
                if (s < 64'(DW)) return x >> s;
                else if (s < 64'(2*DW)) return x << (s - 64'(DW));
                else return '0;
            end
            3'd3: return (x < y) ? DW'(1) : DW'(0);
            default: return x * y;
        endcase
    endfunction

    task automatic push_acc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({1'b0, we, a, d, m_cnt});
    endtask

    // Runs the ISA on mm and records every memory access the core should make.
    task automatic run_model(input int max_instr);
        logic [AW-1:0] pc, npc, a, b, wa, ia;
        logic [DW-1:0] iw, ra, rb, wd, bz;
        logic [2:0]    op;
        logic          im;
        pc = '0;
        m_cnt = '0;
        m_halted = 1'b0;
        for (int n = 0; n < max_instr && !m_halted; n++) begin
            iw = mm[pc];
            push_acc(1'b0, pc, '0);
            op = iw[DW-1:DW-3];
            im = iw[DW-4];
            a  = iw[2*AW-1:AW];
            b  = iw[AW-1:0];
            bz = {{(DW-AW){1'b0}}, b};
            if (op == 3'd6) begin
                if (im) begin
                    ra = mm[a]; push_acc(1'b0, a, '0);
                    npc = ra[AW-1:0] + b;
                end else begin
                    rb = mm[b]; push_acc(1'b0, b, '0);
                    if (rb != '0) begin
                        npc = pc + AW'(1);
                    end else begin
                        ra = mm[a]; push_acc(1'b0, a, '0);
                        npc = ra[AW-1:0];
                    end
                end
                if (npc == pc) m_halted = 1'b1;
                pc = npc;
                m_cnt = m_cnt + CW'(1);
            end else begin
                wa = a;
                case (op)
                    3'd4: begin
                        if (im) wd = bz;
                        else begin rb = mm[b]; push_acc(1'b0, b, '0); wd = rb; end
                    end
                    3'd5: begin
                        if (im) begin
                            ra = mm[a]; push_acc(1'b0, a, '0);
                            wa = ra[AW-1:0];
                            wd = bz;
                        end else begin
                            rb = mm[b]; push_acc(1'b0, b, '0);
                            ia = rb[AW-1:0];
                            push_acc(1'b0, ia, '0);
                            wd = mm[ia];
                        end
                    end
                    default: begin
                        ra = mm[a]; push_acc(1'b0, a, '0);
                        if (im) wd = alu_ref(op, ra, bz);
                        else begin rb = mm[b]; push_acc(1'b0, b, '0); wd = alu_ref(op, ra, rb); end
                    end
                endcase
                push_acc(1'b1, wa, wd);
                mm[wa] = wd;
                pc = pc + AW'(1);
                m_cnt = m_cnt + CW'(1);
            end
        end
    endtask

    // ---------------- responder + monitor / scoreboard ----------------
    // mode 0: always ready, 1: ready every 4th cycle, 2: never ready for writes, 3: random
    initial begin : responder
        logic [EW-1:0] act, exp;
        logic [DW-1:0] wd;
        logic          pend, p_we;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wd;
        pend = 1'b0; p_we = 1'b0; p_addr = '0; p_wd = '0;
        mem_rdy = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                cyc = 0;
                mem_rdy = 1'b0;
                pend = 1'b0;
            end else begin
                cyc++;
                case (rdy_mode)
                    0: mem_rdy = 1'b1;
                    1: mem_rdy = ((cyc % 4) == 0);
                    2: mem_rdy = !mem_we;
                    default: mem_rdy = ($urandom_range(0, 2) != 0);
                endcase
            end
            #1;
            if (rst) begin
                if (pend) begin
                    checks++;
                    if (!(mem_req && mem_we == p_we && mem_addr == p_addr && mem_wdata == p_wd)) begin
                        errors++;
                        $display("FAIL hold: got req=%0b we=%0b addr=%0h wdata=%0h expected req=1 we=%0b addr=%0h wdata=%0h",
                                 mem_req, mem_we, mem_addr, mem_wdata, p_we, p_addr, p_wd);
                    end
                end
                if (mem_req && mem_rdy) begin
                    wd = mem_we ? mem_wdata : '0;
                    act = {halted, mem_we, mem_addr, wd, instr_count};
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL access: got unexpected we=%0b addr=%0h expected no access", mem_we, mem_addr);
                    end else begin
                        exp = exp_q.pop_front();
                        if (act !== exp) begin
                            errors++;
                            $display("FAIL access: got h=%0b we=%0b addr=%0h wd=%0h cnt=%0d expected h=%0b we=%0b addr=%0h wd=%0h cnt=%0d",
                                     act[EW-1], act[EW-2], act[EW-3 -: AW], act[CW+DW-1 -: DW], act[CW-1:0],
                                     exp[EW-1], exp[EW-2], exp[EW-3 -: AW], exp[CW+DW-1 -: DW], exp[CW-1:0]);
                        end
                    end
                    if (mem_we) begin
                        dmem[mem_addr] = mem_wdata;
                        if (first_wr_cyc == 0) first_wr_cyc = cyc;
                    end
                end
                pend   = mem_req && !mem_rdy;
                p_we   = mem_we;
                p_addr = mem_addr;
                p_wd   = mem_wdata;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic hold_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_prog(input int mode, input int max_instr);
        int guard;
        mm = dmem;
        exp_q.delete();
        run_model(max_instr);
        rdy_mode = mode;
        first_wr_cyc = 0;
        @(negedge clk);
        rst = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        check("instr_count", 64'(instr_count), 64'(m_cnt));
        check("halted", 64'(halted), 64'(m_halted));
        if (m_halted) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                #3;
                check("halt_no_req", 64'(mem_req), 64'd0);
            end
        end
        hold_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic [2:0]    op;
        logic          im;
        logic [AW-1:0] a, b;
        int            guard, mode;

        hold_reset();
        #3;
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_cnt", 64'(instr_count), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);

        // ADD, zero wait states
        clear_mem();
        dmem[0]   = 32'h00190065;
        dmem[1]   = enc(3'd6, 1'b1, AW'(1000), AW'(1));
        dmem[100] = 32'd5;
        dmem[101] = 32'd7;
        run_prog(0, 10);
        check("add_wr_cycle", 64'(first_wr_cyc), 64'd4);
        check("add_result", 64'(dmem[100]), 64'd12);

        // same program, ready every 4th cycle
        dmem[100] = 32'd5;
        run_prog(1, 10);
        check("add_wait_wr_cycle", 64'(first_wr_cyc), 64'd16);
        check("add_wait_result", 64'(dmem[100]), 64'd12);

        // SRL register and immediate forms
        clear_mem();
        dmem[0] = enc(3'd2, 1'b0, AW'(100), AW'(101));
        dmem[1] = enc(3'd2, 1'b0, AW'(102), AW'(103));
        dmem[2] = enc(3'd2, 1'b0, AW'(104), AW'(105));
        dmem[3] = enc(3'd2, 1'b1, AW'(106), AW'(3));
        dmem[4] = enc(3'd6, 1'b1, AW'(1000), AW'(4));
        dmem[100] = 32'h80; dmem[101] = 32'd4;
        dmem[102] = 32'h80; dmem[103] = 32'd33;
        dmem[104] = 32'h80; dmem[105] = 32'd64;
        dmem[106] = 32'h80;
        run_prog(3, 10);
        check("srl_4", 64'(dmem[100]), 64'h8);
        check("srl_33", 64'(dmem[102]), 64'h100);
        check("srl_64", 64'(dmem[104]), 64'h0);
        check("srli_3", 64'(dmem[106]), 64'h10);

        // CPI and CPIi
        clear_mem();
        dmem[0]   = enc(3'd5, 1'b0, AW'(110), AW'(111));
        dmem[1]   = enc(3'd5, 1'b1, AW'(112), AW'(9));
        dmem[2]   = enc(3'd6, 1'b1, AW'(1000), AW'(2));
        dmem[111] = 32'd200;
        dmem[200] = 32'hDEAD;
        dmem[112] = 32'd300;
        run_prog(3, 10);
        check("cpi", 64'(dmem[110]), 64'hDEAD);
        check("cpii_target", 64'(dmem[300]), 64'd9);
        check("cpii_a_kept", 64'(dmem[112]), 64'd300);

        // BZJ not taken, taken, BZJi jump, then BZJi self-branch halt
        clear_mem();
        dmem[0]   = enc(3'd6, 1'b0, AW'(120), AW'(121));
        dmem[1]   = enc(3'd6, 1'b0, AW'(122), AW'(123));
        dmem[40]  = enc(3'd6, 1'b1, AW'(124), AW'(5));
        dmem[5]   = enc(3'd6, 1'b1, AW'(125), AW'(5));
        dmem[121] = 32'd1;
        dmem[122] = 32'd40;
        run_prog(0, 10);
        check("bzj_count", 64'(instr_count), 64'd0);
        check("bzj_model_count", 64'(m_cnt), 64'd4);

        // reset asserted while a write is stalled
        clear_mem();
        dmem[0]   = 32'h00190065;
        dmem[1]   = enc(3'd6, 1'b1, AW'(1000), AW'(1));
        dmem[100] = 32'd5;
        dmem[101] = 32'd7;
        mm = dmem;
        exp_q.delete();
        run_model(10);
        rdy_mode = 2;
        @(negedge clk);
        rst = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            #3;
            guard++;
        end while (!(mem_req && mem_we) && guard < 100);
        check("wr_pending", 64'(mem_req && mem_we), 64'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_req", 64'(mem_req), 64'd0);
        check("rst_mid_we", 64'(mem_we), 64'd0);
        check("rst_mid_addr", 64'(mem_addr), 64'd0);
        check("rst_mid_wdata", 64'(mem_wdata), 64'd0);
        check("rst_mid_unwritten", 64'(dmem[100]), 64'd5);
        exp_q.delete();
        repeat (2) @(negedge clk);
        run_prog(0, 10);
        check("rerun_result", 64'(dmem[100]), 64'd12);

        // random programs
        for (int t = 0; t < 6; t++) begin
            clear_mem();
            for (int i = 64; i < 96; i++) begin
                if ($urandom_range(0, 1) == 1) dmem[i] = DW'(64 + $urandom_range(0, 31));
                else dmem[i] = $urandom();
            end
            for (int i = 0; i < 20; i++) begin
                op = 3'($urandom_range(0, 7));
                im = 1'($urandom_range(0, 1));
                a  = AW'(64 + $urandom_range(0, 31));
                b  = im ? AW'($urandom_range(0, 70)) : AW'(64 + $urandom_range(0, 31));
                dmem[i] = enc(op, im, a, b);
            end
            dmem[20] = enc(3'd6, 1'b1, AW'(1000), AW'(20));
            mode = $urandom_range(0, 2);
            if (mode == 2) mode = 3;
            run_prog(mode, 80);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
